// File: rtl/accumulate.sv
// Streaming signed Q8.8 packet accumulator.
// Partial sums saturate to 16 bits. The final add is emitted as a raw
// 17-bit value so the downstream 17-to-16 saturate stage can clamp it.
module accumulate #(
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arg_valid,
  output logic                    arg_ready,
  input  logic signed [15:0]      arg_data,
  input  logic                    arg_last,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [16:0]      res_data,
  output logic [CNT_W-1:0]        res_count
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic signed [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    res_valid_q, res_valid_d;
  logic signed [16:0]      res_data_q, res_data_d;
  logic [CNT_W-1:0]        res_count_q, res_count_d;

  logic                    beat_acc;
  logic signed [16:0]      sum17;

  // Clamp a 17-bit sum back into the 16-bit signed range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] s);
    if (s[16] == s[15]) begin
      sat16 = s[15:0];
    end else if (s[16] == 1'b0) begin
      sat16 = 16'sh7fff;
    end else begin
      sat16 = 16'sh8000;
    end
  endfunction

  // Increment the beat counter, sticking at its maximum value.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      cnt_inc = c;
    end else begin
      cnt_inc = c + 1'b1;
    end
  endfunction

  assign arg_ready = (state_q == ST_ACCUM);
  assign beat_acc  = arg_valid && arg_ready;
  assign sum17     = {acc_q[15], acc_q} + {arg_data[15], arg_data};

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_count = res_count_q;

  // Next-state: accumulate beats, emit on last, hold until downstream takes the result.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    case (state_q)
      ST_ACCUM: begin
        if (beat_acc) begin
          if (arg_last) begin
            // The final add is left unsaturated for the downstream clamp.
            res_data_d  = sum17;
            res_count_d = cnt_inc(cnt_q);
            res_valid_d = 1'b1;
            state_d     = ST_HOLD;
            acc_d       = '0;
            cnt_d       = '0;
          end else begin
            acc_d = sat16(sum17);
            cnt_d = cnt_inc(cnt_q);
          end
        end
      end
      ST_HOLD: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State register; reset clears everything and drops any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
    end
  end

endmodule

// File: tb/tb_accumulate.sv
// Bench for the packet accumulator: vector table, scoreboard and corner sequences.
module tb_accumulate;

  logic               clk;
  logic               rst;
  logic               arg_valid;
  logic               arg_ready;
  logic signed [15:0] arg_data;
  logic               arg_last;
  logic               res_valid;
  logic               res_ready;
  logic signed [16:0] res_data;
  logic [7:0]         res_count;

  accumulate #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .arg_valid (arg_valid),
    .arg_ready (arg_ready),
    .arg_data  (arg_data),
    .arg_last  (arg_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_count (res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [15:0] b [4];
    logic [16:0] d;
    logic [7:0]  c;
  } vec_t;

  typedef struct {
    logic [16:0] d;
    logic [7:0]  c;
  } exp_t;

  vec_t        vecs [8];
  exp_t        sbq [$];
  logic [15:0] pkt [$];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input int n, input logic [15:0] b0, input logic [15:0] b1,
                         input logic [15:0] b2, input logic [15:0] b3,
                         input logic [16:0] d, input logic [7:0] c);
    vecs[i].n    = n;
    vecs[i].b[0] = b0;
    vecs[i].b[1] = b1;
    vecs[i].b[2] = b2;
    vecs[i].b[3] = b3;
    vecs[i].d    = d;
    vecs[i].c    = c;
  endtask

  // Offer one beat until the DUT takes it (bounded).
  task automatic send_beat(input logic [15:0] d, input logic l);
    bit ok;
    ok        = 1'b0;
    arg_valid = 1'b1;
    arg_data  = d;
    arg_last  = l;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (arg_ready) ok = 1'b1;
      tick();
    end
    arg_valid = 1'b0;
    arg_last  = 1'b0;
    if (!ok) chk("beat_timeout", 32'd0, 32'd1);
  endtask

  // Send the beats in pkt (last flag on the final one) and push the expectation.
  task automatic send_pkt(input logic [16:0] d, input logic [7:0] c);
    exp_t e;
    e.d = d;
    e.c = c;
    sbq.push_back(e);
    for (int i = 0; i < pkt.size(); i++) send_beat(pkt[i], (i == pkt.size() - 1));
    pkt.delete();
  endtask

  // Wait for a result with res_ready high, pop the scoreboard and compare.
  task automatic get_result(input string nm);
    bit   got;
    exp_t e;
    got       = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      if (res_valid) begin
        got = 1'b1;
        if (sbq.size() == 0) begin
          chk({nm, "_unexpected"}, 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk({nm, "_data"}, {15'd0, res_data}, {15'd0, e.d});
          chk({nm, "_count"}, {24'd0, res_count}, {24'd0, e.c});
        end
      end
      tick();
    end
    res_ready = 1'b0;
    if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
    else chk({nm, "_ready_after"}, {31'd0, arg_ready}, 32'd1);
  endtask

  // Reference: saturating partial sums, raw final add.
  function automatic logic [16:0] model(input logic [15:0] q [$]);
    int a;
    int s;
    a = 0;
    for (int i = 0; i < q.size() - 1; i++) begin
      s = a + int'($signed(q[i]));
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      a = s;
    end
    s = a + int'($signed(q[q.size() - 1]));
    return s[16:0];
  endfunction

  initial begin
    logic [16:0] md;
    int          n;

    rst       = 1'b1;
    arg_valid = 1'b0;
    arg_data  = '0;
    arg_last  = 1'b0;
    res_ready = 1'b0;

    set_vec(0, 1, 16'h00ff, 16'h0000, 16'h0000, 16'h0000, 17'h000ff, 8'd1);
    set_vec(1, 2, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 17'h08000, 8'd2);
    set_vec(2, 3, 16'h7000, 16'h7000, 16'h8000, 16'h0000, 17'h1ffff, 8'd3);
    set_vec(3, 3, 16'h8000, 16'h8000, 16'h0100, 16'h0000, 17'h18100, 8'd3);
    set_vec(4, 4, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 17'h0000a, 8'd4);
    set_vec(5, 2, 16'hffff, 16'hfffe, 16'h0000, 16'h0000, 17'h1fffd, 8'd2);
    set_vec(6, 2, 16'h7fff, 16'h0001, 16'h0000, 16'h0000, 17'h08000, 8'd2);
    set_vec(7, 2, 16'h8000, 16'hffff, 16'h0000, 16'h0000, 17'h17fff, 8'd2);

    tick();
    tick();
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", {15'd0, res_data}, 32'd0);
    chk("rst_res_count", {24'd0, res_count}, 32'd0);
    chk("rst_arg_ready", {31'd0, arg_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // Vector table.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < vecs[v].n; i++) pkt.push_back(vecs[v].b[i]);
      send_pkt(vecs[v].d, vecs[v].c);
      chk($sformatf("vec%0d_latency", v), {31'd0, res_valid}, 32'd1);
      get_result($sformatf("vec%0d", v));
    end

    // Backpressure: result held, extra beats ignored.
    pkt.push_back(16'h1234);
    send_pkt(17'h01234, 8'd1);
    arg_valid = 1'b1;
    arg_data  = 16'h5555;
    arg_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_data", {15'd0, res_data}, 32'h01234);
      chk("bp_count", {24'd0, res_count}, 32'd1);
      chk("bp_arg_ready", {31'd0, arg_ready}, 32'd0);
      tick();
    end
    arg_valid = 1'b0;
    arg_last  = 1'b0;
    get_result("bp");
    pkt.push_back(16'h0001);
    send_pkt(17'h00001, 8'd1);
    get_result("bp_next");

    // Reset mid-packet: partial sum and count discarded, no result.
    send_beat(16'h1000, 1'b0);
    send_beat(16'h1000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_res_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_arg_ready", {31'd0, arg_ready}, 32'd1);
    tick();
    chk("abort_no_result", {31'd0, res_valid}, 32'd0);
    pkt.push_back(16'h0010);
    send_pkt(17'h00010, 8'd1);
    get_result("abort_next");

    // Beat counter saturation: 300 beats of +1.
    for (int i = 0; i < 300; i++) pkt.push_back(16'h0001);
    send_pkt(17'h0012c, 8'd255);
    get_result("cnt_sat");

    // Random packets against the reference model.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) pkt.push_back(16'($urandom));
      md = model(pkt);
      send_pkt(md, 8'(n));
      get_result($sformatf("rnd%0d", r));
    end

    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
